// File: rtl/decode_pkg.sv
// Shared decode definitions: default field widths, field-offset helpers and the ISA opcode map.
package decode_pkg;

  localparam int unsigned INSTR_W_DEF  = 16;
  localparam int unsigned OPC_W_DEF    = 4;
  localparam int unsigned OPC2_W_DEF   = 3;
  localparam int unsigned REG_BITS_DEF = 2;
  localparam int unsigned SHAMT_W_DEF  = 3;
  localparam int unsigned CONST_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF   = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ALU  = 4'h1, OP_ALUI = 4'h2, OP_SHF  = 4'h3,
    OP_LD   = 4'h4, OP_ST   = 4'h5, OP_LDI  = 4'h6, OP_MOV  = 4'h7,
    OP_BEQ  = 4'h8, OP_BNE  = 4'h9, OP_JMP  = 4'hA, OP_CALL = 4'hB,
    OP_RET  = 4'hC, OP_IN   = 4'hD, OP_OUT  = 4'hE, OP_HALT = 4'hF
  } opcode_e;

  // Fields are packed from the MSB downwards: opcode, then Rm/Rs1/Rs2, then shift amount;
  // opcode2 overlays the bits directly under the opcode.
  function automatic int unsigned opc_lsb(int unsigned instr_w, int unsigned opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int unsigned opc2_lsb(int unsigned instr_w, int unsigned opc_w,
                                           int unsigned opc2_w);
    return instr_w - opc_w - opc2_w;
  endfunction

  function automatic int unsigned reg_lsb(int unsigned instr_w, int unsigned opc_w,
                                          int unsigned reg_bits, int unsigned idx);
    return instr_w - opc_w - (idx + 1) * reg_bits;
  endfunction

  function automatic int unsigned shamt_lsb(int unsigned instr_w, int unsigned opc_w,
                                            int unsigned reg_bits, int unsigned shamt_w);
    return instr_w - opc_w - 3 * reg_bits - shamt_w;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction slicer and immediate sign-extender.
module decode_fields
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned OPC2_W   = 3,
  parameter int unsigned REG_BITS = 2,
  parameter int unsigned SHAMT_W  = 3,
  parameter int unsigned CONST_W  = 8,
  parameter int unsigned DATA_W   = 16
) (
  input  logic [INSTR_W-1:0]  instr_i,
  output logic [OPC_W-1:0]    opcode_o,
  output logic [OPC2_W-1:0]   opcode2_o,
  output logic [REG_BITS-1:0] rm_o,
  output logic [REG_BITS-1:0] rs1_o,
  output logic [REG_BITS-1:0] rs2_o,
  output logic [SHAMT_W-1:0]  shamt_o,
  output logic [CONST_W-1:0]  const_o,
  output logic [DATA_W-1:0]   imm_o
);

  localparam int unsigned OPC_LSB   = opc_lsb(INSTR_W, OPC_W);
  localparam int unsigned OPC2_LSB  = opc2_lsb(INSTR_W, OPC_W, OPC2_W);
  localparam int unsigned RM_LSB    = reg_lsb(INSTR_W, OPC_W, REG_BITS, 0);
  localparam int unsigned RS1_LSB   = reg_lsb(INSTR_W, OPC_W, REG_BITS, 1);
  localparam int unsigned RS2_LSB   = reg_lsb(INSTR_W, OPC_W, REG_BITS, 2);
  localparam int unsigned SHAMT_LSB = shamt_lsb(INSTR_W, OPC_W, REG_BITS, SHAMT_W);

  always_comb begin
    opcode_o  = instr_i[OPC_LSB +: OPC_W];
    opcode2_o = instr_i[OPC2_LSB +: OPC2_W];
    rm_o      = instr_i[RM_LSB +: REG_BITS];
    rs1_o     = instr_i[RS1_LSB +: REG_BITS];
    rs2_o     = instr_i[RS2_LSB +: REG_BITS];
    shamt_o   = instr_i[SHAMT_LSB +: SHAMT_W];
    const_o   = instr_i[CONST_W-1:0];
    imm_o     = DATA_W'($signed(instr_i[CONST_W-1:0]));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (main + skid).
// Optional illegal-opcode flag enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned OPC2_W   = 3,
  parameter int unsigned REG_BITS = 2,
  parameter int unsigned SHAMT_W  = 3,
  parameter int unsigned CONST_W  = 8,
  parameter int unsigned DATA_W   = 16,
  parameter logic [2**OPC_W-1:0] ILLEGAL_MASK = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPC_W-1:0]    opcode,
  output logic [OPC2_W-1:0]   opcode2,
  output logic [REG_BITS-1:0] Rm,
  output logic [REG_BITS-1:0] Rs1,
  output logic [REG_BITS-1:0] Rs2,
  output logic [SHAMT_W-1:0]  shiftamt,
  output logic [CONST_W-1:0]  constant,
  output logic [DATA_W-1:0]   imm_sext,
  output logic                out_illegal
);

  if (OPC_W + 3 * REG_BITS + SHAMT_W > INSTR_W) begin : g_chk_regs
    $error("decode_stage: opcode, register and shift fields exceed INSTR_W");
  end
  if (OPC2_W > INSTR_W - OPC_W) begin : g_chk_opc2
    $error("decode_stage: OPC2_W exceeds INSTR_W-OPC_W");
  end
  if (CONST_W > INSTR_W) begin : g_chk_const
    $error("decode_stage: CONST_W exceeds INSTR_W");
  end
  if (DATA_W < CONST_W) begin : g_chk_data
    $error("decode_stage: DATA_W must be >= CONST_W");
  end

  typedef struct packed {
    logic [OPC_W-1:0]    opcode;
    logic [OPC2_W-1:0]   opcode2;
    logic [REG_BITS-1:0] rm;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [SHAMT_W-1:0]  shamt;
    logic [CONST_W-1:0]  cnst;
    logic [DATA_W-1:0]   imm;
    logic                illegal;
  } entry_t;

  entry_t new_entry;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   in_ready_q, in_ready_d;
  logic   in_xfer, out_xfer;

  decode_fields #(
    .INSTR_W  (INSTR_W),
    .OPC_W    (OPC_W),
    .OPC2_W   (OPC2_W),
    .REG_BITS (REG_BITS),
    .SHAMT_W  (SHAMT_W),
    .CONST_W  (CONST_W),
    .DATA_W   (DATA_W)
  ) u_fields (
    .instr_i   (instruction),
    .opcode_o  (new_entry.opcode),
    .opcode2_o (new_entry.opcode2),
    .rm_o      (new_entry.rm),
    .rs1_o     (new_entry.rs1),
    .rs2_o     (new_entry.rs2),
    .shamt_o   (new_entry.shamt),
    .const_o   (new_entry.cnst),
    .imm_o     (new_entry.imm)
  );

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign new_entry.illegal = ILLEGAL_MASK[new_entry.opcode];
`else
  logic unused_illegal_mask;
  assign unused_illegal_mask = ^ILLEGAL_MASK;
  assign new_entry.illegal   = 1'b0;
`endif

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = main_vld_q & out_ready;

  // Drain first, then fill: a drained main lets the incoming word land directly in main.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (out_xfer) begin
        if (skid_vld_q) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = 1'b0;
        end
      end
      if (in_xfer) begin
        if (!main_vld_d) begin
          main_d     = new_entry;
          main_vld_d = 1'b1;
        end else begin
          skid_d     = new_entry;
          skid_vld_d = 1'b1;
        end
      end
    end
    in_ready_d = ~skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_vld_q;
  assign opcode      = main_q.opcode;
  assign opcode2     = main_q.opcode2;
  assign Rm          = main_q.rm;
  assign Rs1         = main_q.rs1;
  assign Rs2         = main_q.rs2;
  assign shiftamt    = main_q.shamt;
  assign constant    = main_q.cnst;
  assign imm_sext    = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (default widths, ILLEGAL_MASK bit 14 set).
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] instruction;
  logic        in_ready, out_valid, out_illegal;
  logic [3:0]  opcode;
  logic [2:0]  opcode2, shiftamt;
  logic [1:0]  Rm, Rs1, Rs2;
  logic [7:0]  constant;
  logic [15:0] imm_sext;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [15:0] W_A = 16'h1A5C;
  localparam logic [15:0] W_B = 16'hF09C;
  localparam logic [15:0] W_C = 16'h2345;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL_E = 1'b1;
`else
  localparam logic EXP_ILL_E = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_stage #(
    .INSTR_W      (16),
    .OPC_W        (4),
    .OPC2_W       (3),
    .REG_BITS     (2),
    .SHAMT_W      (3),
    .CONST_W      (8),
    .DATA_W       (16),
    .ILLEGAL_MASK (16'h4000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode      (opcode),
    .opcode2     (opcode2),
    .Rm          (Rm),
    .Rs1         (Rs1),
    .Rs2         (Rs2),
    .shiftamt    (shiftamt),
    .constant    (constant),
    .imm_sext    (imm_sext),
    .out_illegal (out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_opcode",    32'(opcode),    32'h0);
    check("rst_imm",       32'(imm_sext),  32'h0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Basic slicing, then back-to-back accept with simultaneous drain.
    in_valid = 1'b1; instruction = W_A; out_ready = 1'b1;
    step();
    check("t1_valid",    32'(out_valid), 32'h1);
    check("t1_opcode",   32'(opcode),    32'h1);
    check("t1_opcode2",  32'(opcode2),   32'h5);
    check("t1_rm",       32'(Rm),        32'h2);
    check("t1_rs1",      32'(Rs1),       32'h2);
    check("t1_rs2",      32'(Rs2),       32'h1);
    check("t1_shamt",    32'(shiftamt),  32'h3);
    check("t1_const",    32'(constant),  32'h5C);
    check("t1_imm",      32'(imm_sext),  32'h005C);
    check("t1_illegal",  32'(out_illegal), 32'h0);
    instruction = W_B;
    step();
    in_valid = 1'b0;
    check("t2_valid",    32'(out_valid), 32'h1);
    check("t2_opcode",   32'(opcode),    32'(OP_HALT));
    check("t2_const",    32'(constant),  32'h9C);
    check("t2_imm",      32'(imm_sext),  32'hFF9C);
    step();
    check("t2_drained",  32'(out_valid), 32'h0);

    // Fill both entries with downstream stalled, then drain in order.
    out_ready = 1'b0; in_valid = 1'b1; instruction = W_A;
    step();
    check("t3_ready_one", 32'(in_ready), 32'h1);
    instruction = W_B;
    step();
    check("t3_full_ready", 32'(in_ready), 32'h0);
    instruction = W_C;
    step(); step();
    check("t3_stall_valid", 32'(out_valid), 32'h1);
    check("t3_stall_const", 32'(constant),  32'h5C);
    check("t3_stall_imm",   32'(imm_sext),  32'h005C);
    out_ready = 1'b1;
    step();
    check("t3_second_const", 32'(constant), 32'h9C);
    check("t3_reopen_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    check("t3_third_valid",  32'(out_valid), 32'h1);
    check("t3_third_opcode", 32'(opcode),    32'h2);
    check("t3_third_const",  32'(constant),  32'h45);
    step();
    check("t3_empty", 32'(out_valid), 32'h0);

    // Flush with both entries full, then flush racing an accept.
    out_ready = 1'b0; in_valid = 1'b1; instruction = W_A;
    step();
    instruction = W_B;
    step();
    in_valid = 1'b0;
    check("t4_full", 32'(in_ready), 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_flush_valid", 32'(out_valid), 32'h0);
    check("t4_flush_ready", 32'(in_ready),  32'h1);
    flush = 1'b1; in_valid = 1'b1; instruction = W_C;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_drop_valid", 32'(out_valid), 32'h0);
    step();
    check("t4_no_stale", 32'(out_valid), 32'h0);

    // Reset in the middle of a stalled output.
    in_valid = 1'b1; instruction = W_A;
    step();
    in_valid = 1'b0;
    check("t5_pre_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    step();
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_const", 32'(constant),  32'h0);
    check("t5_rst_rm",    32'(Rm),        32'h0);
    check("t5_rst_ready", 32'(in_ready),  32'h0);
    rst = 1'b0;
    step();
    out_ready = 1'b1; in_valid = 1'b1; instruction = W_C;
    step();
    in_valid = 1'b0;
    check("t5_opcode",  32'(opcode),   32'h2);
    check("t5_opcode2", 32'(opcode2),  32'h1);
    check("t5_rm",      32'(Rm),       32'h0);
    check("t5_rs1",     32'(Rs1),      32'h3);
    check("t5_rs2",     32'(Rs2),      32'h1);
    check("t5_shamt",   32'(shiftamt), 32'h0);
    check("t5_imm",     32'(imm_sext), 32'h0045);

    // Illegal-opcode flag follows its entry through the buffer.
    in_valid = 1'b1; instruction = {OP_OUT, 12'h123};
    step();
    check("t6_ill_e",    32'(out_illegal), 32'(EXP_ILL_E));
    check("t6_ill_e_op", 32'(opcode),      32'hE);
    instruction = W_A;
    step();
    in_valid = 1'b0;
    check("t6_ill_1", 32'(out_illegal), 32'h0);
    check("t6_op_1",  32'(opcode),      32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
